fir_tap_reader: RTL and testbench
=================================

# fir_tap_reader

Read-side sequencer and MAC for the FIR sample delay line (shift line). For each input sample it pushes the sample into the line, walks every tap address, and reads the tap data and the matching coefficient. It multiply-accumulates one tap per cycle and emits one filtered output word per accepted sample. It sits between the sample source and the output stage, and is the only driver of the shift line's `E`, `w` and `Addr` inputs.

## Interface
- `TAPS`, 64: number of taps; must be ≤ 2^`AW`.
- `AW`, 6: tap address width.
- `DW`, 16: sample width, signed two's complement.
- `CW`, 16: coefficient width, signed.
- `ACCW`, 38: accumulator/output width, = `DW`+`CW`+`AW`.
- `READ_LAT`, 1: cycles from `Addr`/`coef_addr` presented to `Q`/`coef` valid; 0 = combinational.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `R`  in  1: reset, synchronous, active-high.
- `x_in`  in  DW: new input sample.
- `x_valid`  in  1: `x_in` offered this cycle.
- `x_ready`  out  1: block can accept a sample this cycle.
- `E`  out  1: shift enable to the delay line.
- `w`  out  DW: sample written into the delay line.
- `Addr`  out  AW: tap address to the delay line. Addr 0 = newest sample.
- `Q`  in  DW: tap data from the delay line.
- `coef_addr`  out  AW: coefficient address, always equal to `Addr`.
- `coef`  in  CW: coefficient for `coef_addr`.
- `y`  out  ACCW: filtered output, full precision.
- `y_valid`  out  1: one-cycle pulse; `y` is valid.
- `busy`  out  1: high in every state except IDLE.

## Operation
- FSM states: IDLE → SHIFT → SCAN → DRAIN → DONE → IDLE.
- IDLE: `x_ready`=1. When `x_valid`&`x_ready` at an edge, latch `x_in` into `w`, clear `acc`, go to SHIFT.
- SHIFT (1 cycle): `E`=1, `w`=latched sample; the line shifts at the end of this cycle. Next state is SCAN.
- SCAN (`TAPS` cycles): `Addr` = 0, 1, …, `TAPS`-1, one address per cycle.
- DRAIN (`READ_LAT` cycles, skipped if 0): no new addresses; the remaining in-flight products are accumulated.
- Accumulation: for the address presented in cycle c, the signed product `Q*coef` (DW+CW bits) is sign-extended to ACCW and added to `acc` at the end of cycle c+`READ_LAT`. The product valid flag is a `READ_LAT`-deep shift register fed by SCAN.
- DONE (1 cycle): `y`=`acc`, `y_valid`=1. Next state is IDLE.
- `y` holds its value until the next DONE.
- No rounding or saturation. ACCW=38 cannot overflow for TAPS ≤ 64.
- `x_valid` outside IDLE: ignored, sample dropped, no state change.
- `E` is high only in SHIFT. `Addr`/`coef_addr` are 0 outside SCAN. `w` holds the last accepted sample.
- Reset (`R`=1 at an edge, any state): go to IDLE; clear `acc`, `y`, `w`, `Addr` and the valid pipe; `E`=0, `y_valid`=0.
- Reset mid-operation aborts the sample, and no `y_valid` follows. The delay line shares `R` and is cleared with this block.
- `x_ready` = (state==IDLE) & ~`R`. It is 0 during reset and 1 in the first cycle after `R` falls.

## Timing
- Accept at the edge ending cycle 0. SHIFT in cycle 1. SCAN in cycles 2..`TAPS`+1. DRAIN in cycles `TAPS`+2..`TAPS`+1+`READ_LAT`.
- DONE/`y_valid` in cycle `TAPS`+2+`READ_LAT`. With defaults, that is cycle 67.
- Earliest next accept: cycle `TAPS`+3+`READ_LAT` (68 with defaults). Minimum sample period is 68 cycles.
- `y_valid` is exactly 1 cycle wide. It never coincides with `E`.
- The accumulate at the end of cycle c+`READ_LAT` uses `Q`/`coef` sampled in that same cycle. No extra register stage is allowed beyond `READ_LAT`.

## Test plan
- Reset: hold `R` 3 cycles with `x_valid`=1 → `E`=0, `Addr`=0, `y`=0, `y_valid`=0, `x_ready`=0. After `R` falls, `x_ready`=1 on the next cycle, and no sample is accepted during reset.
- Impulse: behavioural shift line, `READ_LAT`=1, coef[k]=k+1. Feed 1, then 0s → nth output `y`=n for n=1..64, then 0. Each `y_valid` arrives exactly 67 cycles after its accept.
- DC fill: all coef=1, `x_in`=10 constant → `y`=10·n for n ≤ 64, then 640 steady.
- Extremes: all coef=-32768, `x_in`=-32768 for 64 samples → final `y`=2^36=68719476736, with no wrap.
- Busy/drop: pulse `x_valid` with `x_in`=99 during SCAN → ignored, result unchanged, `x_ready`=0 throughout. With `x_valid` held high continuously, accepts occur every 68 cycles.
- Reset mid-SCAN: assert `R` at `Addr`=30 → no `y_valid`, `Addr`=0 next cycle. The next sample after reset gives `y`=x·coef[0].

Source files
------------

// File: rtl/fir_tap_reader_if.sv
// Bundle between the FIR tap reader and its neighbours: the sample source, the shift line,
// the coefficient store and the output stage.
interface fir_tap_reader_if #(
   parameter int AW   = 6,
   parameter int DW   = 16,
   parameter int CW   = 16,
   parameter int ACCW = 38
) ();
   logic [DW-1:0]   x_in;
   logic            x_valid;
   logic            x_ready;
   logic            E;
   logic [DW-1:0]   w;
   logic [AW-1:0]   Addr;
   logic [DW-1:0]   Q;
   logic [AW-1:0]   coef_addr;
   logic [CW-1:0]   coef;
   logic [ACCW-1:0] y;
   logic            y_valid;
   logic            busy;

   // Sample handshake: x_in is taken on a rising edge where x_valid and x_ready are both high;
   // x_valid seen while x_ready is low is dropped, and y_valid is a one-cycle pulse with no back-pressure.
   modport master (
      input  x_in, x_valid, Q, coef,
      output x_ready, E, w, Addr, coef_addr, y, y_valid, busy
   );

   modport slave (
      output x_in, x_valid, Q, coef,
      input  x_ready, E, w, Addr, coef_addr, y, y_valid, busy
   );
endinterface

// File: rtl/fir_tap_reader.sv
// Read-side sequencer and MAC for the FIR shift line: pushes one sample, walks every tap,
// and accumulates Q*coef into one full-precision output word per accepted sample.
module fir_tap_reader #(
   parameter int TAPS     = 64,
   parameter int AW       = 6,
   parameter int DW       = 16,
   parameter int CW       = 16,
   parameter int ACCW     = 38,
   parameter int READ_LAT = 1
) (
   input  logic                clk,
   input  logic                R,
   fir_tap_reader_if.master    io,
   output logic [2:0]          dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SHIFT = 3'd1,
      S_SCAN  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [AW-1:0] SCAN_LAST  = AW'(TAPS - 1);
   localparam logic [AW-1:0] DRAIN_LAST = AW'((READ_LAT > 0) ? READ_LAT - 1 : 0);

   state_t                   state, state_nx;
   logic [AW-1:0]            cnt;
   logic [DW-1:0]            w_q;
   logic signed [ACCW-1:0]   acc;
   logic [ACCW-1:0]          y_q;
   logic signed [DW+CW-1:0]  prod;
   logic                     prod_valid;
   logic                     accept;

   assign accept    = (state == S_IDLE) && io.x_valid && !R;
   assign prod      = $signed(io.Q) * $signed(io.coef);
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (R) state <= S_IDLE;
      else   state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      io.x_ready   = 1'b0;
      io.E         = 1'b0;
      io.Addr      = '0;
      io.coef_addr = '0;
      io.y_valid   = 1'b0;
      io.busy      = (state != S_IDLE);
      io.w         = w_q;
      io.y         = y_q;
      case (state)
         S_IDLE: begin
            io.x_ready = !R;
            if (io.x_valid) state_nx = S_SHIFT;
         end
         S_SHIFT: begin
            io.E     = 1'b1;
            state_nx = S_SCAN;
         end
         S_SCAN: begin
            io.Addr      = cnt;
            io.coef_addr = cnt;
            if (cnt == SCAN_LAST) state_nx = (READ_LAT == 0) ? S_DONE : S_DRAIN;
         end
         S_DRAIN: begin
            if (cnt == DRAIN_LAST) state_nx = S_DONE;
         end
         S_DONE: begin
            // The last product landed at the end of the previous cycle, so acc is final here.
            io.y       = acc;
            io.y_valid = 1'b1;
            state_nx   = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // One counter serves both SCAN (tap address) and DRAIN (latency wait); it restarts on every state change.
   always_ff @(posedge clk) begin
      if (R)                      cnt <= '0;
      else if (state_nx != state) cnt <= '0;
      else                        cnt <= cnt + AW'(1);
   end

   generate
      if (READ_LAT == 0) begin : g_comb_read
         assign prod_valid = (state == S_SCAN);
      end else begin : g_piped_read
         logic [READ_LAT-1:0] vpipe;
         always_ff @(posedge clk) begin
            if (R) begin
               vpipe <= '0;
            end else begin
               vpipe    <= vpipe << 1;
               vpipe[0] <= (state == S_SCAN);
            end
         end
         assign prod_valid = vpipe[READ_LAT-1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (R) begin
         acc <= '0;
         w_q <= '0;
         y_q <= '0;
      end else begin
         if (accept) begin
            w_q <= io.x_in;
            acc <= '0;
         end else if (prod_valid) begin
            acc <= acc + ACCW'(prod);
         end
         if (state == S_DONE) y_q <= acc;
      end
   end

endmodule

// File: tb/tb_fir_tap_reader.sv
// Directed bench for fir_tap_reader with a behavioural shift line and coefficient store
// (both one-cycle registered reads).
module tb_fir_tap_reader;
  localparam int TAPS     = 64;
  localparam int AW       = 6;
  localparam int DW       = 16;
  localparam int CW       = 16;
  localparam int ACCW     = 38;
  localparam int READ_LAT = 1;
  localparam int LAT      = TAPS + 2 + READ_LAT;
  localparam int PERIOD   = TAPS + 3 + READ_LAT;

  logic       clk = 1'b0;
  logic       R   = 1'b1;
  logic [2:0] dbg_state;
  int         cyc   = 0;
  int         total = 0;
  int         bad   = 0;

  logic [DW-1:0] line     [TAPS];
  logic [CW-1:0] coef_mem [TAPS];

  fir_tap_reader_if #(.AW(AW), .DW(DW), .CW(CW), .ACCW(ACCW)) bus ();

  fir_tap_reader #(
    .TAPS(TAPS), .AW(AW), .DW(DW), .CW(CW), .ACCW(ACCW), .READ_LAT(READ_LAT)
  ) dut (
    .clk(clk),
    .R(R),
    .io(bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: got no end by cycle %0d, required end earlier", cyc);
    $fatal(1, "watchdog");
  end

  // behavioural shift line and coefficient store
  always @(posedge clk) begin
    if (R) begin
      for (int i = 0; i < TAPS; i++) line[i] <= '0;
    end else if (bus.E) begin
      for (int i = 1; i < TAPS; i++) line[i] <= line[i-1];
      line[0] <= bus.w;
    end
    bus.Q    <= line[bus.Addr];
    bus.coef <= coef_mem[bus.coef_addr];
  end

  // driver tasks (entered and left on a negedge)
  task automatic set_coefs(input bit ramp, input logic [CW-1:0] c);
    for (int k = 0; k < TAPS; k++) coef_mem[k] = ramp ? CW'(k + 1) : c;
  endtask

  task automatic do_reset();
    R = 1'b1;
    bus.x_valid = 1'b0;
    repeat (2) @(negedge clk);
    R = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_sample(input logic [DW-1:0] x, output int acc_cyc);
    int n = 0;
    bus.x_in = x;
    bus.x_valid = 1'b1;
    while (!bus.x_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!bus.x_ready) begin
      bad++;
      $display("FAIL send_ready: got x_ready=0 for %0d cycles, required 1", n);
    end
    acc_cyc = cyc;
    @(negedge clk);
    bus.x_valid = 1'b0;
    total++;
    if (bus.E !== 1'b1 || bus.w !== x) begin
      bad++;
      $display("FAIL shift_cycle: got E=%0b w=%0d, required E=1 w=%0d", bus.E, bus.w, x);
    end
  endtask

  task automatic wait_result(input int acc_cyc, input logic [ACCW-1:0] exp_y, input string name);
    int n = 0;
    while (!bus.y_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!bus.y_valid) begin
      bad++;
      $display("FAIL %s_timeout: got no y_valid in %0d cycles, required one", name, n);
      return;
    end
    total++;
    if (bus.y !== exp_y) begin
      bad++;
      $display("FAIL %s_y: got %0d, required %0d", name, $signed(bus.y), $signed(exp_y));
    end
    total++;
    if (cyc - acc_cyc !== LAT) begin
      bad++;
      $display("FAIL %s_latency: got %0d, required %0d", name, cyc - acc_cyc, LAT);
    end
    total++;
    if (bus.E !== 1'b0) begin
      bad++;
      $display("FAIL %s_E_with_y: got E=%0b, required 0", name, bus.E);
    end
    @(negedge clk);
    total++;
    if (bus.y_valid !== 1'b0 || bus.y !== exp_y) begin
      bad++;
      $display("FAIL %s_hold: got y_valid=%0b y=%0d, required 0 and %0d", name, bus.y_valid,
               $signed(bus.y), $signed(exp_y));
    end
  endtask

  // scenarios
  task automatic test_reset();
    R = 1'b1;
    bus.x_valid = 1'b1;
    bus.x_in = 16'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.E !== 1'b0 || bus.Addr !== '0 || bus.y !== '0 || bus.y_valid !== 1'b0 ||
          bus.x_ready !== 1'b0 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs: got E=%0b Addr=%0d y=%0d y_valid=%0b x_ready=%0b busy=%0b, required all 0",
                 bus.E, bus.Addr, bus.y, bus.y_valid, bus.x_ready, bus.busy);
      end
    end
    bus.x_valid = 1'b0;
    R = 1'b0;
    @(negedge clk);
    total++;
    if (bus.x_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_after: got %0b, required 1", bus.x_ready);
    end
    total++;
    if (bus.busy !== 1'b0 || bus.w !== '0) begin
      bad++;
      $display("FAIL reset_no_accept: got busy=%0b w=%0d, required 0 and 0", bus.busy, bus.w);
    end
  endtask

  task automatic test_impulse();
    int ac;
    do_reset();
    set_coefs(1'b1, '0);
    for (int n = 1; n <= TAPS + 1; n++) begin
      send_sample((n == 1) ? 16'd1 : 16'd0, ac);
      wait_result(ac, (n <= TAPS) ? ACCW'(n) : '0, "impulse");
    end
  endtask

  task automatic test_dc_back_to_back();
    int n = 0;
    int last = -1;
    int budget = 0;
    logic [ACCW-1:0] exp_y;
    do_reset();
    set_coefs(1'b0, 16'd1);
    bus.x_in = 16'd10;
    bus.x_valid = 1'b1;
    while (n < TAPS + 2 && budget < 70 * PERIOD) begin
      if (bus.y_valid) begin
        n++;
        exp_y = ACCW'(10 * ((n < TAPS) ? n : TAPS));
        total++;
        if (bus.y !== exp_y) begin
          bad++;
          $display("FAIL dc_y[%0d]: got %0d, required %0d", n, bus.y, exp_y);
        end
      end
      if (bus.x_ready) begin
        if (last >= 0) begin
          total++;
          if (cyc - last !== PERIOD) begin
            bad++;
            $display("FAIL dc_accept_period: got %0d, required %0d", cyc - last, PERIOD);
          end
        end
        last = cyc;
      end
      @(negedge clk);
      budget++;
    end
    bus.x_valid = 1'b0;
    total++;
    if (n !== TAPS + 2) begin
      bad++;
      $display("FAIL dc_count: got %0d outputs, required %0d", n, TAPS + 2);
    end
  endtask

  task automatic test_extremes();
    int ac;
    logic [ACCW-1:0] exp_y;
    do_reset();
    set_coefs(1'b0, 16'h8000);
    for (int n = 1; n <= TAPS; n++) begin
      send_sample(16'h8000, ac);
      exp_y = ACCW'(64'(n) << 30);
      wait_result(ac, exp_y, "extreme");
    end
    total++;
    if (bus.y !== 38'd68719476736) begin
      bad++;
      $display("FAIL extreme_final: got %0d, required 68719476736", bus.y);
    end
  endtask

  task automatic test_drop();
    int ac;
    int n = 0;
    do_reset();
    set_coefs(1'b1, '0);
    send_sample(16'd5, ac);
    while (bus.Addr !== AW'(10) && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      bus.x_in = 16'd99;
      bus.x_valid = 1'b1;
      total++;
      if (bus.x_ready !== 1'b0 || bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL drop_ready: got x_ready=%0b busy=%0b, required 0 and 1", bus.x_ready, bus.busy);
      end
      @(negedge clk);
    end
    bus.x_valid = 1'b0;
    wait_result(ac, ACCW'(5), "drop_first");
    total++;
    if (bus.w !== 16'd5) begin
      bad++;
      $display("FAIL drop_w: got %0d, required 5", bus.w);
    end
    send_sample(16'd0, ac);
    wait_result(ac, ACCW'(10), "drop_second");
  endtask

  task automatic test_reset_mid_scan();
    int ac;
    int n = 0;
    bit seen = 1'b0;
    do_reset();
    set_coefs(1'b1, '0);
    send_sample(16'd7, ac);
    while (bus.Addr !== AW'(30) && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.Addr !== AW'(30)) begin
      bad++;
      $display("FAIL midreset_reach: got Addr=%0d, required 30", bus.Addr);
    end
    R = 1'b1;
    @(negedge clk);
    total++;
    if (bus.Addr !== '0 || bus.y_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_state: got Addr=%0d y_valid=%0b busy=%0b, required 0 0 0",
               bus.Addr, bus.y_valid, bus.busy);
    end
    R = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.y_valid) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL midreset_no_y: got y_valid=1 after abort, required none");
    end
    send_sample(16'd3, ac);
    wait_result(ac, ACCW'(3), "midreset_next");
  endtask

  initial begin
    bus.x_valid = 1'b0;
    bus.x_in = '0;
    set_coefs(1'b1, '0);
    @(negedge clk);
    test_reset();
    test_impulse();
    test_dc_back_to_back();
    test_extremes();
    test_drop();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
